popcount_acc5: RTL and testbench

- Downstream consumer of the 5:3 counter stage. Takes a stream of 5-bit input groups and reduces each group to a 3-bit weighted triple (cout, carry, sum). The value of each triple is 4*cout + 2*carry + sum, which equals the popcount of the group.
- Accumulates the triples over a frame and delivers the frame's total bit count on a valid/ready output.
- Used for Hamming-weight and ones-density measurement on serial data blocks.

---
 rtl/popcount_acc5.sv | 129 ++++++++++++
 tb/tb_popcount_acc5.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_acc5.sv
`default_nettype none
// ============================================================================
// Module      : popcount_acc5
// Description : 5:3 compressor front end feeding a frame bit-count
//               accumulator with a valid/ready result port.
//               Optional macro POPACC_SAT_EN: saturate instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module popcount_acc5 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [4:0]       x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    localparam logic [1:0] c_st_acc  = 2'd0;
    localparam logic [1:0] c_st_fin  = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic             r_s1_valid;
    logic             r_s1_last;
    logic             r_s1_cout;
    logic             r_s1_carry;
    logic             r_s1_sum;

    logic [CNT_W-1:0] r_acc;
    logic             r_ovf;

    logic             w_accept;
    logic             w_fa1_s;
    logic             w_fa1_c;
    logic             w_fa2_s;
    logic             w_fa2_c;
    logic [2:0]       w_trip;
    logic [CNT_W:0]   w_sum;

    // Two chained full adders: both carries have weight 2, so their sum
    // splits into the carry (weight 2) and cout (weight 4) outputs.
    assign w_fa1_s  = x[0] ^ x[1] ^ x[2];
    assign w_fa1_c  = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
    assign w_fa2_s  = w_fa1_s ^ x[3] ^ x[4];
    assign w_fa2_c  = (w_fa1_s & x[3]) | (w_fa1_s & x[4]) | (x[3] & x[4]);

    assign w_accept = in_valid && in_ready;
    assign w_trip   = {r_s1_cout, r_s1_carry, r_s1_sum};
    assign w_sum    = {1'b0, r_acc} + {{(CNT_W-2){1'b0}}, w_trip};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_acc;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; FIN gives the final sum one cycle to settle into acc
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_acc:  if (r_s1_valid && r_s1_last) w_state_nxt = c_st_fin;
            c_st_fin:  w_state_nxt = c_st_hold;
            c_st_hold: if (out_ready) w_state_nxt = c_st_acc;
            default:   w_state_nxt = c_st_acc;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready  = (r_state == c_st_acc) && !(r_s1_valid && r_s1_last);
        out_valid = (r_state == c_st_hold);
        out_count = r_acc;
        out_ovf   = r_ovf;
    end

    // Compress stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_cout  <= 1'b0;
            r_s1_carry <= 1'b0;
            r_s1_sum   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_last  <= in_last;
                r_s1_cout  <= w_fa1_c & w_fa2_c;
                r_s1_carry <= w_fa1_c ^ w_fa2_c;
                r_s1_sum   <= w_fa2_s;
            end
        end
    end

    // Accumulate stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == c_st_hold && out_ready) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_s1_valid) begin
            r_ovf <= r_ovf | w_sum[CNT_W];
`ifdef POPACC_SAT_EN
            if (w_sum[CNT_W] || r_ovf) begin
                r_acc <= '1;
            end else begin
                r_acc <= w_sum[CNT_W-1:0];
            end
`else
            r_acc <= w_sum[CNT_W-1:0];
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_popcount_acc5.sv
`default_nettype none
// ============================================================================
// Module      : tb_popcount_acc5
// Description : Self-checking bench for popcount_acc5 (CNT_W=16 and CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_acc5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [4:0]  x = 5'd0;
    logic        out_ready = 1'b1;

    logic        in_ready16, out_valid16, out_ovf16;
    logic [15:0] out_count16;
    logic        in_ready4, out_valid4, out_ovf4;
    logic [3:0]  out_count4;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    popcount_acc5 #(.CNT_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .in_last(in_last), .x(x), .out_valid(out_valid16), .out_ready(out_ready),
        .out_count(out_count16), .out_ovf(out_ovf16)
    );

    popcount_acc5 #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .in_last(in_last), .x(x), .out_valid(out_valid4), .out_ready(out_ready),
        .out_count(out_count4), .out_ovf(out_ovf4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // Frame total as seen through a w-bit counter
    function automatic longint exp_cnt(input longint t, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        if (t > mx) begin
`ifdef POPACC_SAT_EN
            return mx;
`else
            return t & mx;
`endif
        end
        return t;
    endfunction

    // Behavioural model: frame totals and handshake timing
    longint     m_total = 0;
    longint     m_fin = 0;
    bit         m_pend = 1'b0;
    int         m_since = 0;
    bit         m_s1v = 1'b0;
    logic [4:0] m_s1x = 5'd0;
    bit         m_ev;
    bit         m_acc;

    always @(posedge clk) begin
        if (rst) begin
            m_total = 0;
            m_pend  = 1'b0;
            m_since = 0;
            m_s1v   = 1'b0;
        end else begin
            m_ev  = m_pend && (m_since >= 2);
            m_acc = in_valid && !m_pend;
            m_s1v = m_acc;
            m_s1x = x;
            if (m_pend) begin
                if (m_ev && out_ready) m_pend = 1'b0;
                else m_since++;
            end
            if (m_acc) begin
                m_total += longint'($countones(x));
                if (in_last) begin
                    m_fin   = m_total;
                    m_total = 0;
                    m_pend  = 1'b1;
                    m_since = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready16", 64'(in_ready16), 64'(!m_pend));
            chk("in_ready4", 64'(in_ready4), 64'(!m_pend));
            chk("out_valid16", 64'(out_valid16), 64'(m_pend && m_since >= 2));
            chk("out_valid4", 64'(out_valid4), 64'(m_pend && m_since >= 2));
            if (m_pend && m_since >= 2) begin
                chk("out_count16", 64'(out_count16), 64'(exp_cnt(m_fin, 16)));
                chk("out_ovf16", 64'(out_ovf16), 64'(m_fin > 65535));
                chk("out_count4", 64'(out_count4), 64'(exp_cnt(m_fin, 4)));
                chk("out_ovf4", 64'(out_ovf4), 64'(m_fin > 15));
            end
            chk("s1_valid", 64'(dut16.r_s1_valid), 64'(m_s1v));
            if (m_s1v) begin
                chk("s1_triple",
                    64'(4 * dut16.r_s1_cout + 2 * dut16.r_s1_carry + dut16.r_s1_sum),
                    64'($countones(m_s1x)));
            end
        end
    end

    // Present one beat and hold it until accepted; returns at a falling edge
    task automatic send(input logic [4:0] xv, input bit last);
        bit done = 1'b0;
        in_valid = 1'b1;
        x        = xv;
        in_last  = last;
        for (int i = 0; i < 200 && !done; i++) begin
            if (in_ready16) done = 1'b1;
            @(negedge clk);
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom);
            x        = 5'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic wait_out(input string name, input logic [15:0] exp16);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (out_valid16) seen = 1'b1;
            else @(negedge clk);
        end
        chk({name, "_seen"}, 64'(seen), 64'd1);
        chk({name, "_count"}, 64'(out_count16), 64'(exp16));
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && m_pend; i++) begin
            out_ready = 1'($urandom);
            @(negedge clk);
        end
        chk("drain_timeout", 64'(m_pend), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_in_ready", 64'(in_ready16), 64'd1);
        chk("rst_out_valid", 64'(out_valid16), 64'd0);
        chk("rst_out_count", 64'(out_count16), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf16), 64'd0);

        // Single-beat frame and its latency
        send(5'b10110, 1'b1);
        chk("t1_lat_k", 64'(out_valid16), 64'd0);
        @(negedge clk);
        chk("t1_lat_k1", 64'(out_valid16), 64'd0);
        @(negedge clk);
        chk("t1_lat_k2", 64'(out_valid16), 64'd1);
        chk("t1_count", 64'(out_count16), 64'd3);
        chk("t1_ovf", 64'(out_ovf16), 64'd0);
        @(negedge clk);
        chk("t1_drop", 64'(out_valid16), 64'd0);

        // Four back-to-back beats
        send(5'b11111, 1'b0);
        send(5'b00000, 1'b0);
        send(5'b00001, 1'b0);
        send(5'b11000, 1'b1);
        wait_out("t2", 16'd8);
        @(negedge clk);

        // Every 5-bit pattern in one frame
        for (int i = 0; i < 32; i++) send(5'(i), i == 31);
        wait_out("t3", 16'd80);
        @(negedge clk);

        // Back-pressure on the result with input pressure behind it
        out_ready = 1'b0;
        send(5'b01011, 1'b0);
        send(5'b00011, 1'b1);
        wait_out("t4", 16'd5);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = 5'($urandom);
            chk("t4_hold_count", 64'(out_count16), 64'd5);
            chk("t4_hold_ready", 64'(in_ready16), 64'd0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        send(5'b00001, 1'b1);
        wait_out("t4_next", 16'd1);
        @(negedge clk);

        // Overflow on the narrow instance
        for (int i = 0; i < 4; i++) send(5'b11111, i == 3);
        wait_out("t5", 16'd20);
`ifdef POPACC_SAT_EN
        chk("t5_count4", 64'(out_count4), 64'd15);
`else
        chk("t5_count4", 64'(out_count4), 64'd4);
`endif
        chk("t5_ovf4", 64'(out_ovf4), 64'd1);
        @(negedge clk);
        chk("t5_ovf4_clr", 64'(out_ovf4), 64'd0);

        // Reset mid-frame
        send(5'b11111, 1'b0);
        send(5'b00011, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        send(5'b00111, 1'b1);
        wait_out("t6", 16'd3);
        @(negedge clk);

        // Randomized frames with gaps and random result back-pressure
        for (int f = 0; f < 40; f++) begin
            int len;
            len = int'($urandom_range(1, 8));
            for (int b = 0; b < len; b++) begin
                out_ready = 1'($urandom);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
                send(5'($urandom), b == len - 1);
            end
            drain();
        end

        idle(4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
